axi4_single_os_arbiter: RTL and testbench

- Shares one AXI4 master port between N_REQ simple single-word requesters.
- Only one transaction is outstanding at a time across both the read and write channels. The port therefore satisfies single-outstanding environment properties by construction.
- Round-robin grant; single-beat bursts only.
- Sits between internal bus clients (e.g. instruction/data ports, debug) and the external AXI4 fabric.

---
 rtl/axi4_single_os_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_axi4_single_os_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_single_os_arbiter.sv
// Round-robin arbiter that multiplexes N_REQ single-word requesters onto one AXI4 master port.
// At most one read or write transaction is in flight at any time; all bursts are single-beat.
module axi4_single_os_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*32-1:0]     req_wdata,
  input  logic [N_REQ*4-1:0]      req_be,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_W-1:0]       araddr,
  output logic [ID_W-1:0]         arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic [ID_W-1:0]         rid,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [ID_W-1:0]         awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [PTR_W-1:0]   id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               arvalid_q;
  logic               awvalid_q;
  logic               wvalid_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     cand;
  logic [ID_W-1:0]    id_ext;
  logic               grant_now;

  // First pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      if (!gnt_found && req_valid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign rr_ptr_d  = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
  assign id_ext    = ID_W'(id_q);
  // Gated by rst so no accept pulse escapes while the port is held in reset.
  assign grant_now = rst && (state_q == IDLE) && gnt_found;
  assign req_ready = grant_now ? (N_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            if (req_we[gnt_idx]) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arvalid_q && arready) begin
            arvalid_q <= 1'b0;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rsp_valid_q <= N_REQ'(1) << id_q;
            rsp_rdata_q <= rdata;
            rsp_err_q   <= (rresp != 2'b00) | (rid != id_ext) | ~rlast;
            state_q     <= IDLE;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; move on once both have been taken.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (bvalid) begin
            rsp_valid_q <= N_REQ'(1) << id_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= (bresp != 2'b00) | (bid != id_ext);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload capture; it only reaches the bus behind a registered valid.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && gnt_found) begin
      addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      wdata_q <= req_wdata[gnt_idx*32 +: 32];
      be_q    <= req_be[gnt_idx*4 +: 4];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = id_ext;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign rready  = (state_q == RD_DATA);

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awid    = id_ext;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = be_q;
  assign wlast   = wvalid_q;
  assign bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_axi4_single_os_arbiter.sv
// Bench for axi4_single_os_arbiter: directed requests, a configurable AXI slave,
// and a scoreboard monitor that checks every response against queued expectations.
module tb_axi4_single_os_arbiter;
  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_we = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*32-1:0]     req_wdata = '0;
  logic [N_REQ*4-1:0]      req_be = '0;
  logic [N_REQ-1:0]        req_ready, rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    arvalid, arready;
  logic [ADDR_W-1:0]       araddr, awaddr;
  logic [ID_W-1:0]         arid, awid, rid, bid;
  logic [7:0]              arlen, awlen;
  logic [2:0]              arsize, awsize;
  logic [1:0]              arburst, awburst, rresp, bresp;
  logic                    rvalid, rready, rlast;
  logic [31:0]             rdata, wdata;
  logic                    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]              wstrb;

  axi4_single_os_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] exp_addr [N_REQ];

  // Slave behaviour knobs
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] cfg_rdata = 32'hDEADBEEF;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic        cfg_rlast = 1'b1, cfg_rid_bad = 1'b0, cfg_bid_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid, req_ready, rsp_err}), 64'd0);
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // AXI slave: drives its inputs 2 time units after each rising edge.
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [ID_W-1:0] last_arid, last_awid;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    last_arid = '0; last_awid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    forever begin
      @(posedge clk); #2;
      if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; last_arid = arid; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (rready) begin rvalid = (r_cnt >= r_delay); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
      rid   = cfg_rid_bad ? (last_arid ^ ID_W'(1)) : last_arid;
      rdata = cfg_rdata;
      rresp = cfg_rresp;
      rlast = cfg_rlast;
      if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; last_awid = awid; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      bid   = cfg_bid_bad ? (last_awid ^ ID_W'(1)) : last_awid;
      bresp = cfg_bresp;
    end
  end

  // Monitor: protocol checks and scoreboard, sampled mid-cycle.
  initial begin
    logic ar_open, aw_open;
    exp_t e;
    int a, ai;
    ar_open = 1'b0; aw_open = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ar_open = 1'b0; aw_open = 1'b0;
      end else begin
        if (arvalid && arready) begin
          check("ar_single_outstanding", 64'({ar_open, aw_open}), 64'd0);
          ai = int'(arid);
          check("arid_range", 64'(ai < N_REQ), 64'd1);
          if (ai < N_REQ) check("araddr", 64'(araddr), 64'(exp_addr[ai]));
          ar_open = 1'b1;
        end
        if (rvalid && rready) ar_open = 1'b0;
        if (awvalid && awready) begin
          check("aw_single_outstanding", 64'({ar_open, aw_open}), 64'd0);
          ai = int'(awid);
          check("awid_range", 64'(ai < N_REQ), 64'd1);
          if (ai < N_REQ) check("awaddr", 64'(awaddr), 64'(exp_addr[ai]));
          aw_open = 1'b1;
        end
        if (bvalid && bready) aw_open = 1'b0;
        if (req_ready != '0) acc_q.push_back(cyc);
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: rsp_valid=%b with no expected response (cycle %0d)", rsp_valid, cyc);
          end else begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
            check("rsp_valid_onehot", 64'(rsp_valid), 64'd1 << e.idx);
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_latency", 64'(cyc - a), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic do_req(input int idx, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    bit got;
    e.idx = idx; e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
    exp_addr[idx] = addr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_we[idx] = we;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[idx*32 +: 32] = wd;
    req_be[idx*4 +: 4] = be;
    req_valid[idx] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: requester %0d never saw req_ready", idx);
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    req_addr[idx*ADDR_W +: ADDR_W] = $urandom;
    req_wdata[idx*32 +: 32] = $urandom;
    req_be[idx*4 +: 4] = 4'($urandom);
    req_we[idx] = ~we;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    for (int i = 0; i < N_REQ; i++) exp_addr[i] = '0;

    // Reset state
    #12;
    check_quiet("reset_outputs");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_quiet("post_reset_idle");

    // Single read from requester 0
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3);
    @(negedge clk);
    check("t1_arvalid", 64'(arvalid), 64'd1);
    check("t1_arid", 64'(arid), 64'd0);
    check("t1_ar_const", 64'({arlen, arsize, arburst}), 64'({8'd0, 3'b010, 2'b01}));
    wait_idle();

    // Write from requester 1 with a slow AW channel
    aw_delay = 3;
    do_req(1, 1'b1, 32'h40, 32'hCAFE1234, 4'b0011, 32'h0, 1'b0, 6);
    @(negedge clk);
    check("t2_aw_w_at1", 64'({awvalid, wvalid, wlast}), 64'b111);
    check("t2_awid", 64'(awid), 64'd1);
    check("t2_wdata", 64'(wdata), 64'h0000_0000_CAFE_1234);
    check("t2_wstrb", 64'(wstrb), 64'b0011);
    check("t2_aw_const", 64'({awlen, awsize, awburst}), 64'({8'd0, 3'b010, 2'b01}));
    @(negedge clk);
    check("t2_at2", 64'({awvalid, wvalid, wlast}), 64'b100);
    @(negedge clk);
    check("t2_at3", 64'({awvalid, wvalid, bready}), 64'b100);
    @(negedge clk);
    check("t2_at4", 64'({awvalid, awready, bready}), 64'b110);
    @(negedge clk);
    check("t2_at5", 64'({awvalid, wvalid, bready}), 64'b001);
    wait_idle();
    aw_delay = 0;

    // Both requesters read continuously: grants alternate 0,1,0,1
    exp_addr[0] = 32'h200;
    exp_addr[1] = 32'h300;
    for (int g = 0; g < 4; g++) begin
      exp_t e;
      e.idx = g % 2; e.rdata = 32'h1234_5678; e.err = 1'b0; e.lat = 3;
      exp_q.push_back(e);
    end
    cfg_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_addr = {32'h300, 32'h200};
    req_we = '0;
    req_valid = 2'b11;
    ng = 0;
    for (int t = 0; t < 100 && ng < 4; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), 64'd1 << (ng % 2));
        ng++;
      end
    end
    if (ng < 4) begin
      checks++; errors++;
      $display("FAIL rr_timeout: only %0d of 4 grants", ng);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Error responses
    cfg_bresp = 2'b10;
    do_req(0, 1'b1, 32'h80, 32'h1111_2222, 4'hF, 32'h0, 1'b1, 3);
    wait_idle();
    cfg_bresp = 2'b00;
    cfg_rid_bad = 1'b1;
    cfg_rdata = 32'hA5A5_0001;
    do_req(1, 1'b0, 32'h84, 32'h0, 4'hF, 32'hA5A5_0001, 1'b1, 3);
    wait_idle();
    cfg_rid_bad = 1'b0;
    cfg_rlast = 1'b0;
    do_req(0, 1'b0, 32'h88, 32'h0, 4'hF, 32'hA5A5_0001, 1'b1, 3);
    wait_idle();
    cfg_rlast = 1'b1;
    cfg_bid_bad = 1'b1;
    do_req(1, 1'b1, 32'h8C, 32'h3333_4444, 4'h1, 32'h0, 1'b1, 3);
    wait_idle();
    cfg_bid_bad = 1'b0;
    do_req(0, 1'b0, 32'h90, 32'h0, 4'hF, 32'hA5A5_0001, 1'b0, 3);
    wait_idle();

    // Reset while waiting in RD_DATA
    r_delay = 20;
    do_req(1, 1'b0, 32'h500, 32'h0, 4'hF, 32'h0, 1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_rd_data", 64'(rready), 64'd1);
    @(posedge clk); #1;
    req_addr[0 +: ADDR_W] = 32'h700;
    req_we[0] = 1'b0;
    req_valid[0] = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_quiet("t5_reset_async");
    @(negedge clk);
    check_quiet("t5_reset_held");
    r_delay = 0;
    req_valid[0] = 1'b0;
    #1;
    rst = 1'b1;
    cfg_rdata = 32'h0BAD_F00D;
    do_req(1, 1'b0, 32'h600, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 3);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
